float_copro_master: RTL and testbench

//  CPU-side initiator for the float coprocessor handshake (valid/opcode/op0/op1 -> complete/result -> accept).

---
 rtl/float_copro_master.sv | 166 ++++++++++++++++
 tb/tb_float_copro_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_copro_master.sv
// CPU-side initiator: queues float ops, issues one at a time to the coprocessor, returns result or timeout.
// Push-to-issue >=2 cycles, complete-to-response 1 cycle; req_ready drops when FIFO full, no issue while a response is unconsumed.
module float_copro_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int T_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] req_opcode,
    input  logic [31:0] req_op0,
    input  logic [31:0] req_op1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [10:0] rsp_opcode,
    output logic        rsp_timeout,
    output logic        copro_valid,
    output logic [10:0] copro_opcode,
    output logic [31:0] copro_op0,
    output logic [31:0] copro_op1,
    input  logic        copro_complete,
    input  logic [31:0] copro_result,
    output logic        copro_accept,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(T_TIMEOUT + 1);
    localparam int EW = 11 + 32 + 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACCEPT,
        S_RECOVER
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [WW-1:0] r_wd;
    logic [10:0]   r_cop_opcode;
    logic [31:0]   r_cop_op0;
    logic [31:0]   r_cop_op1;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_result;
    logic [10:0]   r_rsp_opcode;
    logic          r_rsp_timeout;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_wd_expired;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push       = req_valid && !w_full;
    assign w_wd_expired = (r_wd == WW'(T_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A complete seen in IDLE is a leftover from a reset or timeout; it is acknowledged and dropped.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (copro_complete) begin
                    w_next = S_ACCEPT;
                end else if (!w_empty && !r_rsp_valid) begin
                    w_next = S_ISSUE;
                    w_pop  = 1'b1;
                end
            end
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT: begin
                if (copro_complete) begin
                    w_next = S_ACCEPT;
                end else if (w_wd_expired) begin
                    w_next = S_RECOVER;
                end
            end
            S_ACCEPT:  w_next = S_IDLE;
            S_RECOVER: begin
                if (copro_complete) begin
                    w_next = S_ACCEPT;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {req_opcode, req_op0, req_op1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_wd          <= '0;
            r_cop_opcode  <= '0;
            r_cop_op0     <= '0;
            r_cop_op1     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_opcode  <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                {r_cop_opcode, r_cop_op0, r_cop_op1} <= r_mem[r_rd_ptr[AW-1:0]];
            end
            if (r_state == S_ISSUE) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd <= r_wd + WW'(1);
            end
            // WAIT is only reachable with rsp_valid low, so capture and consume never collide.
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid   <= 1'b0;
                r_rsp_result  <= '0;
                r_rsp_opcode  <= '0;
                r_rsp_timeout <= 1'b0;
            end else if (r_state == S_WAIT && copro_complete) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_result  <= copro_result;
                r_rsp_opcode  <= r_cop_opcode;
                r_rsp_timeout <= 1'b0;
            end else if (r_state == S_WAIT && w_wd_expired) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_result  <= '0;
                r_rsp_opcode  <= r_cop_opcode;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign req_ready    = !w_full;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_opcode   = r_rsp_opcode;
    assign rsp_timeout  = r_rsp_timeout;
    assign copro_valid  = (r_state == S_ISSUE);
    assign copro_accept = (r_state == S_ACCEPT);
    assign copro_opcode = r_cop_opcode;
    assign copro_op0    = r_cop_op0;
    assign copro_op1    = r_cop_op1;
    assign busy         = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_float_copro_master.sv
// Directed bench for float_copro_master with a scripted coprocessor model and response monitor.
module tb_float_copro_master;
    localparam int TT = 16;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [10:0] req_opcode;
    logic [31:0] req_op0, req_op1;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [10:0] rsp_opcode;
    logic        rsp_timeout;
    logic        copro_valid;
    logic [10:0] copro_opcode;
    logic [31:0] copro_op0, copro_op1;
    logic        copro_complete;
    logic [31:0] copro_result;
    logic        copro_accept;
    logic        busy;

    float_copro_master #(.FIFO_DEPTH(4), .T_TIMEOUT(TT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_op0(req_op0), .req_op1(req_op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_opcode(rsp_opcode), .rsp_timeout(rsp_timeout),
        .copro_valid(copro_valid), .copro_opcode(copro_opcode),
        .copro_op0(copro_op0), .copro_op1(copro_op1),
        .copro_complete(copro_complete), .copro_result(copro_result),
        .copro_accept(copro_accept), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] opc;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [10:0] opc;
        logic        to;
    } rsp_t;

    typedef struct {
        logic [10:0] opc;
        logic [31:0] a;
        logic [31:0] b;
    } iss_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat_q[$];
    logic [31:0] res_q[$];
    rsp_t        rsp_q[$];
    iss_t        iss_q[$];
    int          n_issue = 0, n_valid_cyc = 0, n_acc_cyc = 0, stab_err = 0;
    int          kick_req = 0, kick_done = 0;

    // Coprocessor model: one op at a time, latency/result taken from the script queues; empty script = hang.
    initial begin : copro_model
        bit          pending;
        int          cnt;
        logic [31:0] res;
        iss_t        cur;
        pending = 0; cnt = 0; res = '0;
        cur = '{opc: '0, a: '0, b: '0};
        copro_complete = 1'b0;
        copro_result   = '0;
        forever begin
            @(negedge clk);
            if (copro_valid)  n_valid_cyc++;
            if (copro_accept) n_acc_cyc++;
            if (copro_complete) begin
                if (copro_accept) begin
                    copro_complete = 1'b0;
                    copro_result   = '0;
                end
            end else if (pending) begin
                if (copro_opcode !== cur.opc || copro_op0 !== cur.a || copro_op1 !== cur.b) stab_err++;
                if (cnt > 0) cnt--;
                if (cnt == 0 || (cnt < 0 && kick_req != kick_done)) begin
                    if (cnt < 0) kick_done++;
                    copro_complete = 1'b1;
                    copro_result   = res;
                    pending        = 0;
                end
            end else if (copro_valid) begin
                n_issue++;
                cur = '{opc: copro_opcode, a: copro_op0, b: copro_op1};
                iss_q.push_back(cur);
                pending = 1;
                if (lat_q.size() > 0) begin
                    cnt = lat_q.pop_front();
                    res = res_q.pop_front();
                end else begin
                    cnt = -1;
                    res = 32'hBAD0BAD0;
                end
            end else if (kick_req != kick_done) begin
                kick_done++;
                copro_complete = 1'b1;
                copro_result   = 32'h5A5A5A5A;
            end
        end
    end

    initial begin : rsp_monitor
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready)
                rsp_q.push_back('{res: rsp_result, opc: rsp_opcode, to: rsp_timeout});
        end
    end

    initial begin : global_guard
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic push_req(logic [10:0] opc, logic [31:0] a, logic [31:0] b);
        int k;
        req_valid = 1'b1; req_opcode = opc; req_op0 = a; req_op1 = b;
        k = 0;
        while (!req_ready && k < 100) begin tick(); k++; end
        check("push_ready", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(int n, int budget, string name);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < budget) begin tick(); k++; end
        check(name, 32'(rsp_q.size() >= n), 1);
    endtask

    vec_t vecs[5];

    initial begin : main
        rsp_t r;
        iss_t s;
        int   i0, a0, v0, r0, k, bad;
        logic [31:0] snap_res;
        logic [10:0] snap_opc;

        vecs[0] = '{opc: 11'd0, a: 32'h3F800000, b: 32'h40000000, lat: 2,  res: 32'h40400000};
        vecs[1] = '{opc: 11'd1, a: 32'h40400000, b: 32'h3F800000, lat: 3,  res: 32'h40000000};
        vecs[2] = '{opc: 11'd2, a: 32'h40000000, b: 32'h40400000, lat: 1,  res: 32'h40C00000};
        vecs[3] = '{opc: 11'd3, a: 32'h40C00000, b: 32'h40000000, lat: 12, res: 32'h40400000};
        vecs[4] = '{opc: 11'd0, a: 32'h40000000, b: 32'h40000000, lat: TT, res: 32'h40800000};

        rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_op0 = '0; req_op1 = '0; rsp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_req_ready", 32'(req_ready), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_copro_valid", 32'(copro_valid), 0);
        check("reset_copro_accept", 32'(copro_accept), 0);
        check("reset_rsp_result", rsp_result, 0);

        // Single operations, including complete arriving on the last allowed WAIT cycle.
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i0 = n_issue; a0 = n_acc_cyc; v0 = n_valid_cyc; r0 = rsp_q.size();
            lat_q.push_back(vecs[i].lat);
            res_q.push_back(vecs[i].res);
            push_req(vecs[i].opc, vecs[i].a, vecs[i].b);
            wait_rsp(r0 + 1, 100, "single_rsp_arrived");
            repeat (3) tick();
            if (rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                check("single_result", r.res, vecs[i].res);
                check("single_opcode", 32'(r.opc), 32'(vecs[i].opc));
                check("single_timeout", 32'(r.to), 0);
            end
            if (iss_q.size() > 0) begin
                s = iss_q.pop_front();
                check("issued_opcode", 32'(s.opc), 32'(vecs[i].opc));
                check("issued_op0", s.a, vecs[i].a);
                check("issued_op1", s.b, vecs[i].b);
            end
            check("copro_valid_pulses", 32'(n_valid_cyc - v0), 1);
            check("copro_accept_pulses", 32'(n_acc_cyc - a0), 1);
            check("issue_count", 32'(n_issue - i0), 1);
        end
        check("operands_stable_in_wait", 32'(stab_err), 0);

        // Blocked response: FIFO fills, response held, no second issue.
        rsp_ready = 1'b0;
        i0 = n_issue;
        lat_q.push_back(2); res_q.push_back(32'h40000000);
        for (int i = 0; i < 4; i++) begin
            lat_q.push_back(vecs[i].lat); res_q.push_back(vecs[i].res);
        end
        push_req(11'd2, 32'h3F800000, 32'h40000000);
        k = 0;
        while (!rsp_valid && k < 100) begin tick(); k++; end
        check("blocker_rsp_valid", 32'(rsp_valid), 1);
        snap_res = rsp_result; snap_opc = rsp_opcode;
        check("blocker_result", snap_res, 32'h40000000);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_opcode = vecs[i].opc; req_op0 = vecs[i].a; req_op1 = vecs[i].b;
            check("b2b_ready", 32'(req_ready), 1);
            tick();
        end
        req_valid = 1'b0;
        check("full_req_ready_low", 32'(req_ready), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_result !== snap_res || rsp_opcode !== snap_opc || rsp_timeout !== 1'b0) bad++;
        end
        check("held_rsp_stable", 32'(bad), 0);
        check("held_no_second_issue", 32'(n_issue - i0), 1);
        check("held_busy", 32'(busy), 1);
        rsp_ready = 1'b1;
        wait_rsp(5, 300, "b2b_all_rsp");
        repeat (3) tick();
        if (rsp_q.size() == 5) begin
            r = rsp_q.pop_front();
            check("b2b_blocker_opcode", 32'(r.opc), 2);
            for (int i = 0; i < 4; i++) begin
                r = rsp_q.pop_front();
                check("b2b_order_opcode", 32'(r.opc), 32'(i));
                check("b2b_result", r.res, vecs[i].res);
            end
        end
        iss_q.delete();
        check("b2b_idle_busy", 32'(busy), 0);

        // Timeout: coprocessor hangs, late complete is accepted but not reported.
        rsp_ready = 1'b0;
        push_req(11'd3, 32'h3F800000, 32'h00000000);
        k = 0;
        while (!copro_valid && k < 20) begin tick(); k++; end
        check("to_issued", 32'(copro_valid), 1);
        k = 0;
        while (!rsp_valid && k < 100) begin tick(); k++; end
        check("to_wait_cycles", 32'(k), 32'(TT + 1));
        check("to_flag", 32'(rsp_timeout), 1);
        check("to_result_zero", rsp_result, 0);
        check("to_opcode", 32'(rsp_opcode), 3);
        rsp_ready = 1'b1;
        wait_rsp(1, 10, "to_rsp_consumed");
        if (rsp_q.size() > 0) r = rsp_q.pop_front();
        a0 = n_acc_cyc;
        kick_req++;
        k = 0;
        while (n_acc_cyc == a0 && k < 20) begin tick(); k++; end
        repeat (4) tick();
        check("late_complete_accepted", 32'(n_acc_cyc - a0), 1);
        check("late_result_not_reported", 32'(rsp_q.size()), 0);
        check("late_busy", 32'(busy), 0);
        iss_q.delete();

        // Stale complete while idle.
        a0 = n_acc_cyc; i0 = n_issue;
        kick_req++;
        repeat (6) tick();
        check("stale_accepted", 32'(n_acc_cyc - a0), 1);
        check("stale_no_rsp", 32'(rsp_q.size()), 0);
        check("stale_no_issue", 32'(n_issue - i0), 0);

        // Reset during WAIT with two queued requests.
        lat_q.push_back(30); res_q.push_back(32'h11111111);
        push_req(11'd1, 32'h40000000, 32'h3F800000);
        push_req(11'd2, 32'h40000000, 32'h40000000);
        push_req(11'd3, 32'h40000000, 32'h40000000);
        repeat (2) tick();
        check("pre_reset_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_copro_valid", 32'(copro_valid), 0);
        check("rst_copro_opcode", 32'(copro_opcode), 0);
        check("rst_copro_op0", copro_op0, 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        tick();
        rst = 1'b0;
        i0 = n_issue; r0 = rsp_q.size(); a0 = n_acc_cyc;
        repeat (45) tick();
        check("rst_fifo_lost", 32'(n_issue - i0), 0);
        check("rst_no_rsp", 32'(rsp_q.size() - r0), 0);
        check("rst_stale_complete_accepted", 32'(n_acc_cyc - a0), 1);
        check("rst_final_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
